// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage and IF/ID pipeline register.
//
// Holds the PC, presents it to instruction memory, and latches the fetched
// word together with PC+4 into IF/ID for decode. Stall freezes everything,
// redirect reloads the PC and squashes the wrong-path fetch with a bubble,
// and halt parks the stage in a sticky HALTED state until reset.
//
// Ports:
//   CLK, RST              core clock; asynchronous active-high reset
//   stall                 freeze PC and IF/ID (from hazard unit)
//   redirect, redirect_pc taken branch/jump from EX and its target
//   halt                  halt instruction sitting in ID
//   imem_addr, imem_data  combinational instruction-memory read port
//   IF_ID_inst/pc4/valid  IF/ID pipeline register outputs
//   fetch_cnt, stall_cnt  saturating perf counters (FETCH_PERF_CNT_EN only)
//
// Build option: define FETCH_PERF_CNT_EN to add the two perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  logic [0:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt, pc4;
  logic [31:0] inst_nxt, pc4_nxt;
  logic        valid_nxt;

  // Decoded edge actions, in priority order; only meaningful in RUN.
  logic run, do_redirect, do_stall, do_halt, do_fetch;

  assign pc4         = pc + 32'd4;   // wraps modulo 2^32
  assign imem_addr   = pc;
  assign run         = (state == S_RUN);
  assign do_redirect = run & redirect;
  assign do_stall    = run & ~redirect & stall;
  assign do_halt     = run & ~redirect & ~stall & halt;
  assign do_fetch    = run & ~redirect & ~stall & ~halt;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = IF_ID_inst;
    pc4_nxt   = IF_ID_pc4;
    valid_nxt = IF_ID_valid;
    if (do_redirect) begin
      // The instruction now in ID is wrong-path, so redirect wins over
      // stall and halt; low address bits are dropped to keep PC aligned.
      pc_nxt    = {redirect_pc[31:2], 2'b00};
      inst_nxt  = NOP_INSTR;
      pc4_nxt   = 32'd0;
      valid_nxt = 1'b0;
    end else if (do_halt) begin
      state_nxt = S_HALTED;
      inst_nxt  = NOP_INSTR;
      pc4_nxt   = 32'd0;
      valid_nxt = 1'b0;
    end else if (do_fetch) begin
      pc_nxt    = pc4;
      inst_nxt  = imem_data;
      pc4_nxt   = pc4;
      valid_nxt = 1'b1;
    end
    // do_stall and HALTED: everything holds (defaults above).
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      IF_ID_inst  <= NOP_INSTR;
      IF_ID_pc4   <= 32'd0;
      IF_ID_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      IF_ID_inst  <= inst_nxt;
      IF_ID_pc4   <= pc4_nxt;
      IF_ID_valid <= valid_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (do_fetch && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
      if (do_stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- directed self-checking bench for fetch_stage.
// Instruction memory returns 32'hC0DE_0000 | addr[15:0], so every expected
// instruction word below is written out by hand from its address.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall, redirect, halt;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] IF_ID_inst, IF_ID_pc4;
  logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  assign imem_data = 32'hC0DE_0000 | {16'h0, imem_addr[15:0]};

  fetch_stage dut (
    .CLK         (CLK),
    .RST         (RST),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .IF_ID_inst  (IF_ID_inst),
    .IF_ID_pc4   (IF_ID_pc4),
    .IF_ID_valid (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] inst,
                          input logic [31:0] p4, input logic v, input logic [31:0] addr);
    chk({tag, ".inst"},  IF_ID_inst, inst);
    chk({tag, ".pc4"},   IF_ID_pc4, p4);
    chk({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, v});
    chk({tag, ".addr"},  imem_addr, addr);
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'd0;
    #12;
    chk_ifid("reset", 32'h0, 32'h0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset.fcnt", fetch_cnt, 32'd0);
    chk("reset.scnt", stall_cnt, 32'd0);
`endif
    RST = 1'b0;

    // Free-running fetch of A, B
    step(); chk_ifid("runA", 32'hC0DE_0000, 32'h4, 1'b1, 32'h4);
    step(); chk_ifid("runB", 32'hC0DE_0004, 32'h8, 1'b1, 32'h8);

    // Two-cycle stall at PC=8, then C resumes from the frozen PC
    stall = 1'b1;
    step(); chk_ifid("stall1", 32'hC0DE_0004, 32'h8, 1'b1, 32'h8);
    step(); chk_ifid("stall2", 32'hC0DE_0004, 32'h8, 1'b1, 32'h8);
    stall = 1'b0;
    step(); chk_ifid("runC", 32'hC0DE_0008, 32'hC, 1'b1, 32'hC);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt.stall", stall_cnt, 32'd2);
    chk("cnt.fetch", fetch_cnt, 32'd3);
`endif

    // Redirect beats stall; low target bits are dropped
    redirect = 1'b1; redirect_pc = 32'h0000_0103; stall = 1'b1;
    step(); chk_ifid("redir.bubble", 32'h0, 32'h0, 1'b0, 32'h100);
    redirect = 1'b0; stall = 1'b0;
    step(); chk_ifid("redir.tgt", 32'hC0DE_0100, 32'h104, 1'b1, 32'h104);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt.stall2", stall_cnt, 32'd2);
`endif

    // PC+4 wraps at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); chk_ifid("wrap.bubble", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step(); chk_ifid("wrap.fetch", 32'hC0DE_FFFC, 32'h0, 1'b1, 32'h0);

    // Back-to-back redirects: last one wins
    redirect = 1'b1; redirect_pc = 32'h200;
    step(); chk_ifid("b2b.1", 32'h0, 32'h0, 1'b0, 32'h200);
    redirect_pc = 32'h300;
    step(); chk_ifid("b2b.2", 32'h0, 32'h0, 1'b0, 32'h300);
    redirect = 1'b0;
    step(); chk_ifid("b2b.tgt", 32'hC0DE_0300, 32'h304, 1'b1, 32'h304);

    // Halt under stall is not acted on
    halt = 1'b1; stall = 1'b1;
    step(); chk_ifid("halt.stalled", 32'hC0DE_0300, 32'h304, 1'b1, 32'h304);
    stall = 1'b0;
    step(); chk_ifid("halt.taken", 32'h0, 32'h0, 1'b0, 32'h304);
    halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h400; stall = 1'b1;
    step(); chk_ifid("halted.redir", 32'h0, 32'h0, 1'b0, 32'h304);
    redirect = 1'b0; stall = 1'b0;
    step(); chk_ifid("halted.hold", 32'h0, 32'h0, 1'b0, 32'h304);

    // Reset leaves HALTED
    #2; RST = 1'b1; #1;
    chk_ifid("halt.rst", 32'h0, 32'h0, 1'b0, 32'h0);
    RST = 1'b0;
    step(); chk_ifid("rst.runA", 32'hC0DE_0000, 32'h4, 1'b1, 32'h4);

    // Async reset mid-cycle during a stall
    stall = 1'b1;
    step(); chk_ifid("st.hold", 32'hC0DE_0000, 32'h4, 1'b1, 32'h4);
    #2; RST = 1'b1; #1;
    chk_ifid("async.rst", 32'h0, 32'h0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("async.scnt", stall_cnt, 32'd0);
`endif
    RST = 1'b0; stall = 1'b0;
    step(); chk_ifid("restart", 32'hC0DE_0000, 32'h4, 1'b1, 32'h4);

    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. It holds the PC, drives the instruction-memory address, and latches the fetched word and PC+4 into IF/ID for decode. It is the direct consumer of the hazard unit's `stall` output and of the EX-stage branch/jump redirect. On a stall it freezes; on a redirect it squashes the wrong-path fetch by inserting a bubble.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000: word placed in IF/ID for a bubble (sll $0,$0,0).
- `CLK`  in  1  core clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  from hazard unit; freeze PC and IF/ID.
- `redirect`  in  1  taken branch or jump resolved in EX.
- `redirect_pc`  in  32  target address for `redirect`.
- `halt`  in  1  decode has a halt instruction in ID.
- `imem_addr`  out  32  current PC; instruction memory reads it combinationally.
- `imem_data`  in  32  instruction word at `imem_addr`, valid in the same cycle.
- `IF_ID_inst`  out  32  registered instruction.
- `IF_ID_pc4`  out  32  registered PC+4 of that instruction.
- `IF_ID_valid`  out  1  1 = real instruction, 0 = bubble.
- `fetch_cnt`  out  32  present only with `FETCH_PERF_CNT_EN`.
- `stall_cnt`  out  32  present only with `FETCH_PERF_CNT_EN`.

## Operation
- FSM has two states:
  - RUN: the reset state.
  - HALTED: sticky; only `RST` leaves it.
- Reset values:
  - PC = RESET_PC.
  - `IF_ID_inst` = NOP_INSTR.
  - `IF_ID_pc4` = 0.
  - `IF_ID_valid` = 0.
  - State = RUN.
  - Counters = 0.
- `imem_addr` = PC at all times. PC is register-driven, not combinational from inputs.
- In RUN, edge priority is highest first:
  1. `redirect`:
     - PC <= {redirect_pc[31:2], 2'b00}.
     - IF/ID <= bubble (inst = NOP_INSTR, valid = 0, pc4 = 0).
     - Overrides `stall` and `halt`, because the ID instruction is wrong-path.
  2. `stall`: PC, `IF_ID_inst`, `IF_ID_pc4` and `IF_ID_valid` all hold.
  3. `halt`:
     - Next state is HALTED.
     - PC holds.
     - IF/ID <= bubble.
  4. Otherwise:
     - PC <= PC+4.
     - `IF_ID_inst` <= `imem_data`.
     - `IF_ID_pc4` <= PC+4.
     - `IF_ID_valid` <= 1.
- In HALTED:
  - PC holds.
  - IF/ID holds the bubble.
  - `stall`, `redirect` and `halt` are ignored.
- Arithmetic: PC+4 is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.
- `redirect_pc[1:0]` are ignored; the PC is always word-aligned.

## Timing
- Fetch latency is one cycle. The word at PC in cycle n appears on `IF_ID_inst` in cycle n+1.
- Stall is applied in the same cycle it is asserted. Asserting `stall` in cycle n keeps the cycle-n IF/ID contents in cycle n+1.
- The fetch that resumes after deassertion reads the same PC that was frozen; nothing is lost or duplicated.
- Redirect has a one-cycle bubble:
  - `redirect` in cycle n gives `IF_ID_valid` = 0 and `imem_addr` = target in cycle n+1.
  - The target instruction is in IF/ID in cycle n+2.
- Back-to-back redirects: each one reloads the PC and inserts a bubble; the last one wins.
- `halt` with `stall` = 1 is not acted on. The halting instruction stays in ID and is re-sampled once the stall clears.
- `RST` asserted mid-operation takes effect immediately without waiting for `CLK`. All outputs take their reset values while `RST` = 1. The first fetch edge is the first `CLK` rise after deassertion.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_cnt` increments on every edge that loads IF/ID with `IF_ID_valid` <= 1.
  - `stall_cnt` increments on every edge in RUN with `stall` = 1 and `redirect` = 0.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: both ports and both registers are absent. Fetch behaviour is identical in both builds.

## Test plan
- Reset then 3 free-running cycles, imem[0,4,8] = A,B,C:
  - IF_ID_inst = A, B, C on successive cycles.
  - IF_ID_pc4 = 4, 8, 12.
  - valid = 1.
- `stall` = 1 for 2 cycles with PC = 8:
  - `imem_addr` stays 8.
  - IF_ID holds B/pc4 8 for both cycles.
  - After release, IF_ID = C/pc4 12.
  - `stall_cnt` = 2.
- `redirect` = 1 with `redirect_pc` = 32'h0000_0103 and `stall` = 1 in the same cycle:
  - Next cycle `imem_addr` = 32'h100 and valid = 0.
  - The following cycle IF_ID = imem[0x100]/pc4 0x104.
- `halt` = 1 with stall = 0: valid goes to 0 and PC freezes. Subsequent `redirect` pulses are ignored. `RST` restores PC = RESET_PC.
- `redirect_pc` = 32'hFFFF_FFFC: IF_ID_pc4 = 32'h0000_0000 and the next `imem_addr` = 0.
- `RST` pulsed asynchronously between clock edges during a stall: outputs go to reset values immediately, and fetch restarts at RESET_PC.
